seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that shares the single `seven_seg_decoder` code path among all eight digits of the board's seven-segment display. It holds a double-buffered 8×4-bit digit store, steps a one-hot active-low anode select across enabled digits at a prescaled rate, and drives the 4-bit code that feeds the shared decoder plus the decimal point. Host logic (encoder/mux result path or test switches) writes digits into a shadow buffer and commits them atomically at a frame boundary.

---
 rtl/seg_scan_ctrl.sv | 102 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with double-buffered digit store.
// Optional anode/DP blanking at slot start when SEG_SCAN_BLANK_EN is defined.
module seg_scan_ctrl #(
    parameter int unsigned DIV = 100000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [3:0] wr_data,
    input  logic       commit_req,
    input  logic [7:0] digit_en,
    input  logic [7:0] dp_mask,
    output logic [3:0] seg_d,
    output logic [7:0] an,
    output logic       dp,
    output logic       frame_tick,
    output logic       commit_ack
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic          pending;
    logic [3:0]    shadow [8];
    logic [3:0]    active [8];

    logic slot_end;
    logic frame_end;
    logic commit_fire;
    logic blank;

    assign slot_end    = (pcnt == PCNT_LAST);
    assign frame_end   = slot_end && (idx == 3'd7);
    // A request arriving on the frame-end cycle itself is served by this copy.
    assign commit_fire = frame_end && (pending || commit_req);

`ifdef SEG_SCAN_BLANK_EN
    localparam logic [PW-1:0] BLANK_LEN = PW'(DIV / 16);
    assign blank = (pcnt < BLANK_LEN);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (slot_end) begin
            pcnt <= '0;
            idx  <= idx + 3'd1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= 1'b0;
        end else if (commit_fire) begin
            pending <= 1'b0;
        end else if (commit_req) begin
            pending <= 1'b1;
        end
    end

    // Copy reads pre-edge shadow, so a same-cycle write lands only in shadow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (wr_en)
                shadow[wr_idx] <= wr_data;
            if (commit_fire) begin
                for (int unsigned i = 0; i < 8; i++)
                    active[i] <= shadow[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_d      <= '0;
            an         <= '1;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
            commit_ack <= 1'b0;
        end else begin
            seg_d      <= active[idx];
            an         <= (digit_en[idx] && !blank) ? ~(8'b1 << idx) : 8'hFF;
            dp         <= ~(dp_mask[idx] & digit_en[idx] & ~blank);
            frame_tick <= frame_end;
            commit_ack <= commit_fire;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at DIV=16: scan order, commit timing,
// enables/DP, async reset; expectations adapt when SEG_SCAN_BLANK_EN is set.
module tb_seg_scan_ctrl;

    localparam int unsigned DIV = 16;
`ifdef SEG_SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_idx = '0;
    logic [3:0] wr_data = '0;
    logic       commit_req = 1'b0;
    logic [7:0] digit_en = 8'hFF;
    logic [7:0] dp_mask = 8'h00;
    logic [3:0] seg_d;
    logic [7:0] an;
    logic       dp;
    logic       frame_tick;
    logic       commit_ack;

    seg_scan_ctrl #(.DIV(DIV)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .commit_req (commit_req),
        .digit_en   (digit_en),
        .dp_mask    (dp_mask),
        .seg_d      (seg_d),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick),
        .commit_ack (commit_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] de;
        logic [7:0] dm;
        logic [7:0] an;
        logic       dp;
        logic [3:0] seg;
        logic       ft;
        logic       ack;
    } vec_t;

    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    // Blanking covers only the first cycle of each slot when DIV=16.
    function automatic logic first_of_slot(input int k);
        return BLANK && (((k - 1) % DIV) == 0);
    endfunction

    task automatic apply_vec(input int i);
        digit_en = vecs[i].de;
        dp_mask  = vecs[i].dm;
        run_to(vecs[i].k);
        chk("an",         an,         first_of_slot(vecs[i].k) ? 8'hFF : vecs[i].an);
        chk("dp",         dp,         first_of_slot(vecs[i].k) ? 1'b1 : vecs[i].dp);
        chk("seg_d",      seg_d,      vecs[i].seg);
        chk("frame_tick", frame_tick, vecs[i].ft);
        chk("commit_ack", commit_ack, vecs[i].ack);
    endtask

    initial begin
        //           k    de     dm     an     dp    seg   ft    ack
        vecs[0]  = '{1,   8'hFF, 8'h00, 8'hFE, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{16,  8'hFF, 8'h00, 8'hFE, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[2]  = '{17,  8'hFF, 8'h00, 8'hFD, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[3]  = '{33,  8'hFF, 8'h00, 8'hFB, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[4]  = '{113, 8'hFF, 8'h00, 8'h7F, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[5]  = '{127, 8'hFF, 8'h00, 8'h7F, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[6]  = '{128, 8'hFF, 8'h00, 8'h7F, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[7]  = '{129, 8'hFF, 8'h00, 8'hFE, 1'b1, 4'h0, 1'b0, 1'b0};
        // Sparse enables, all DPs requested; commit pending since cycle 521.
        vecs[8]  = '{535, 8'h05, 8'hFF, 8'hFF, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[9]  = '{550, 8'h05, 8'hFF, 8'hFB, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[10] = '{565, 8'h05, 8'hFF, 8'hFF, 1'b1, 4'h9, 1'b0, 1'b0};
        vecs[11] = '{625, 8'h05, 8'hFF, 8'hFF, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[12] = '{640, 8'h05, 8'hFF, 8'hFF, 1'b1, 4'h0, 1'b1, 1'b1};
        vecs[13] = '{645, 8'h05, 8'hFF, 8'hFE, 1'b0, 4'h5, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_an", an, 8'hFF);
        chk("rst_dp", dp, 1'b1);
        chk("rst_seg_d", seg_d, 4'h0);
        chk("rst_frame_tick", frame_tick, 1'b0);
        chk("rst_commit_ack", commit_ack, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        cyc = 0;

        // First frame: anode walk and frame tick
        for (int i = 0; i < 8; i++) apply_vec(i);

        // Uncommitted write stays invisible, then commits at frame end
        wr_en = 1'b1; wr_idx = 3'd3; wr_data = 4'h9;
        step();
        wr_en = 1'b0;
        run_to(180);
        chk("slot3_precommit", seg_d, 4'h0);
        run_to(199);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        run_to(255);
        chk("ack_early", commit_ack, 1'b0);
        step();
        chk("ack_frame_end", commit_ack, 1'b1);
        chk("tick_with_ack", frame_tick, 1'b1);
        step();
        chk("ack_one_cycle", commit_ack, 1'b0);
        run_to(310);
        chk("slot3_committed", seg_d, 4'h9);

        // Write + commit_req on the frame-end cycle
        run_to(383);
        wr_en = 1'b1; wr_idx = 3'd0; wr_data = 4'h5; commit_req = 1'b1;
        step();
        wr_en = 1'b0; commit_req = 1'b0;
        chk("ack_same_cycle_req", commit_ack, 1'b1);
        step();
        chk("ack_no_repeat", commit_ack, 1'b0);
        run_to(390);
        chk("slot0_old_value", seg_d, 4'h0);
        run_to(512);
        chk("no_second_ack", commit_ack, 1'b0);
        chk("tick_frame4", frame_tick, 1'b1);
        run_to(520);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;

        // Live enables / DP mask, plus second commit landing at cycle 640
        for (int i = 8; i < 14; i++) apply_vec(i);

        // Async reset mid-slot 5 with a commit pending
        digit_en = 8'hFF; dp_mask = 8'hFF;
        wr_en = 1'b1; wr_idx = 3'd2; wr_data = 4'hA;
        step();
        wr_en = 1'b0;
        run_to(699);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        run_to(725);
        chk("pre_reset_an", an, 8'hDF);
        chk("pre_reset_dp", dp, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_an", an, 8'hFF);
        chk("async_dp", dp, 1'b1);
        chk("async_seg_d", seg_d, 4'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cyc = 0;
        run_to(1);
        chk("restart_an", an, first_of_slot(1) ? 8'hFF : 8'hFE);
        run_to(55);
        chk("restart_slot3_an", an, 8'hF7);
        chk("restart_slot3_seg", seg_d, 4'h0);
        run_to(128);
        chk("restart_tick", frame_tick, 1'b1);
        chk("discarded_commit", commit_ack, 1'b0);
        run_to(150);
        chk("discarded_active", seg_d, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
